// File: rtl/verin_pwm_drive.sv
// Tiller actuator PWM driver with direction dead-time and end-stop gating.
// Latency: pwm_o is registered one cycle after the period counter; end-stop flags one cycle after inputs.
// No backpressure: free-running drive, direction changes stall PWM for DEADTIME cycles.
module verin_pwm_drive #(
    parameter int DEADTIME = 1000  // must be >= 1
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [15:0] freq,
    input  logic [15:0] duty,
    input  logic        sens,
    input  logic [11:0] angle_barre,
    input  logic [11:0] butee_g,
    input  logic [11:0] butee_d,
    output logic        pwm_o,
    output logic        sens_o,
    output logic        fin_course_g,
    output logic        fin_course_d,
    output logic        dead_o
);

    localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEADTIME - 1);

    typedef enum logic {
        RUN  = 1'b0,
        DEAD = 1'b1
    } state_t;

    state_t        state_q;
    logic [DW-1:0] dead_cnt_q;
    logic          sens_q;

    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   freq_l_q, freq_l_d;
    logic [15:0]   duty_l_q, duty_l_d;
    logic          pwm_q, pwm_d;
    logic          fin_g_q, fin_d_q;

    logic          freq_short;
    logic          wrap;
    logic          go_dead;
    logic          dead_exit;
    logic          reload;
    logic          raw_pwm;
    logic          blocked;

    // A period shorter than 2 cycles is treated as "PWM off" and keeps the shadows transparent.
    assign freq_short = (freq_l_q < 16'd2);
    assign wrap       = (cnt_q == (freq_l_q - 16'd1));
    assign go_dead    = (state_q == RUN) && (sens != sens_q);
    assign dead_exit  = (state_q == DEAD) && (dead_cnt_q == '0);
    assign reload     = freq_short || wrap || dead_exit;
    assign raw_pwm    = !freq_short && (cnt_q < duty_l_q);
    // Only the end-stop in the direction of travel blocks; the reverse way stays free.
    assign blocked    = sens_q ? fin_d_q : fin_g_q;

    // Period counter and shadow registers: settings only take effect on a period boundary.
    always_comb begin
        cnt_d    = cnt_q + 16'd1;
        freq_l_d = freq_l_q;
        duty_l_d = duty_l_q;
        if (reload) begin
            cnt_d    = '0;
            freq_l_d = freq;
            duty_l_d = duty;
        end
    end

    // PWM is suppressed while dead, on the cycle DEAD is entered, and on the exit cycle
    // (whose counter value belongs to the aborted period).
    always_comb begin
        pwm_d = raw_pwm && (state_q == RUN) && !go_dead && !blocked;
    end

    // Period counter, shadows and registered PWM output.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cnt_q    <= '0;
            freq_l_q <= '0;
            duty_l_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            freq_l_q <= freq_l_d;
            duty_l_q <= duty_l_d;
            pwm_q    <= pwm_d;
        end
    end

    // End-stop flags are tracked continuously, independent of direction.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            fin_g_q <= 1'b0;
            fin_d_q <= 1'b0;
        end else begin
            fin_g_q <= (angle_barre <= butee_g);
            fin_d_q <= (angle_barre >= butee_d);
        end
    end

    // Direction FSM: any requested reversal runs the full dead time; the direction
    // applied at exit is whatever is requested then, so a bounce-back is harmless.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= RUN;
            dead_cnt_q <= '0;
            sens_q     <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (sens != sens_q) begin
                        state_q    <= DEAD;
                        dead_cnt_q <= DEAD_LOAD;
                    end
                end
                DEAD: begin
                    if (dead_cnt_q == '0) begin
                        state_q <= RUN;
                        sens_q  <= sens;
                    end else begin
                        dead_cnt_q <= dead_cnt_q - 1'b1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign pwm_o        = pwm_q;
    assign sens_o       = sens_q;
    assign fin_course_g = fin_g_q;
    assign fin_course_d = fin_d_q;
    assign dead_o       = (state_q == DEAD);

endmodule

// File: doc/verin_pwm_drive.md
VERIN_PWM_DRIVE -- requirements
Module: verin_pwm_drive

Interface
REQ-001 Parameter DEADTIME, default 1000: clock cycles of forced-off PWM inserted on every direction change.
REQ-002 clk_clk  in  1  system clock; all state on rising edge.
REQ-003 reset_reset_n  in  1  asynchronous, active-low reset.
REQ-004 freq  in  16  PWM period in clock cycles.
REQ-005 duty  in  16  PWM high time in clock cycles.
REQ-006 sens  in  1  requested direction: 1 = angle increasing (toward butee_d), 0 = angle decreasing (toward butee_g).
REQ-007 angle_barre  in  12  current tiller angle, unsigned.
REQ-008 butee_g  in  12  left end-stop threshold, unsigned.
REQ-009 butee_d  in  12  right end-stop threshold, unsigned.
REQ-010 pwm_o  out  1  actuator PWM drive.
REQ-011 sens_o  out  1  applied actuator direction.
REQ-012 fin_course_g  out  1  registered (angle_barre <= butee_g).
REQ-013 fin_course_d  out  1  registered (angle_barre >= butee_d).
REQ-014 dead_o  out  1  high while in the DEAD state.

Function
REQ-015 Period counter cnt (16 bit) shall count 0 .. freq_l-1 and then wrap to 0, where freq_l and duty_l are shadow copies of freq and duty.
REQ-016 freq_l and duty_l shall load from freq and duty only on the wrap cycle (cnt = freq_l-1), or on any cycle while freq_l < 2; mid-period input changes shall have no effect until the next wrap.
REQ-017 While freq_l < 2, cnt shall hold at 0 and the raw PWM shall be 0.
REQ-018 Raw PWM = (cnt < duty_l); duty_l = 0 gives 0 %, and duty_l >= freq_l gives 100 %.
REQ-019 fin_course_g and fin_course_d shall update every cycle regardless of direction, with 1-cycle latency from angle_barre and the thresholds.
REQ-020 blocked = (sens_o = 1 and fin_course_d = 1) or (sens_o = 0 and fin_course_g = 1).
REQ-021 pwm_o shall be a registered output equal to raw PWM AND state = RUN AND NOT blocked; latency is 1 cycle from cnt.
REQ-022 The FSM shall have two states, RUN and DEAD.
REQ-023 In RUN, if sens /= sens_o, the FSM shall go to DEAD, load a dead-time counter with DEADTIME-1, and force pwm_o to 0 from the next cycle.
REQ-024 In DEAD, the dead-time counter shall decrement each cycle.
REQ-025 At DEAD count 0: sens_o shall take the current value of sens, cnt shall reset to 0, freq_l and duty_l shall reload, and the FSM shall return to RUN.
REQ-026 If sens toggles back during DEAD, the dead time shall still complete in full; sens_o takes the sens value present at exit, and may therefore be unchanged.
REQ-027 sens_o shall change only at DEAD exit, never in RUN.
REQ-028 When blocked, only pwm_o is gated; cnt keeps running, and motion resumes on the next raw-high cycle once blocked clears.
REQ-029 The opposite direction is always allowed: a sens reversal away from an active end-stop proceeds through DEAD normally.
REQ-030 If butee_g >= butee_d (misconfiguration), both flags may assert and pwm_o is 0 in both directions; this is accepted behaviour.
REQ-031 All comparisons shall be unsigned with no width extension beyond the operands.

Reset
REQ-032 While reset_reset_n = 0, immediately: pwm_o = 0, sens_o = 0, fin_course_g = 0, fin_course_d = 0, dead_o = 0, state = RUN, cnt = 0, freq_l = 0, duty_l = 0, dead-time counter = 0.
REQ-033 After release, the first rising edge loads freq_l and duty_l (since freq_l < 2), and cnt starts at 0 on the following edge.
REQ-034 Reset asserted during DEAD shall abort DEAD immediately; sens_o returns to 0.

Verification
REQ-035 freq = 100, duty = 25, sens = 0, angle = 2048, butee_g = 100, butee_d = 4000 -> pwm_o high 25 of every 100 cycles, period exactly 100, fin flags 0.
REQ-036 duty changed 25 -> 60 at cnt = 10 -> current period keeps 25 high cycles; the next period has 60 high cycles.
REQ-037 DEADTIME = 8, sens 0 -> 1 during RUN -> pwm_o = 0 and dead_o = 1 for 8 cycles, then sens_o = 1 and a fresh period starts at cnt = 0.
REQ-038 sens_o = 1, angle ramps to 4000 with butee_d = 4000 -> fin_course_d = 1 one cycle later and pwm_o = 0 the cycle after. Then sens = 0 -> DEAD, then PWM resumes with fin_course_d still 1.
REQ-039 Edge duty/freq values: freq = 1 -> pwm_o constantly 0; freq = 50 with duty = 50 -> pwm_o constantly 1; freq = 50 with duty = 0 -> pwm_o constantly 0.
REQ-040 Reset pulse mid-DEAD (DEADTIME = 8, 3 cycles in) -> all outputs 0 immediately; after release, pwm_o resumes per REQ-033 with sens_o = 0.
